fetch_decode: RTL and testbench
===============================

# fetch_decode

Front-end stage of the picoMIPS core: owns the program counter, drives the synchronous program ROM, and registers decoded instruction fields. Its outputs feed the register file read ports (`rs_addr`, `rd_addr`) and the signed Q2.3 `immediate` operand consumed by the MULTI unit and other execute-stage operators. It supports stall, branch redirect with squash, and a sticky halt.

## Interface
- `PC_WIDTH`, 8: program counter and ROM address width.
- `HALT_OP`, 3'b111: opcode value treated as HALT.

- `clk`  in  1  single clock; all state updates on rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  execute-side back-pressure; freezes the stage.
- `branch_taken`  in  1  redirect request from execute, valid for one cycle.
- `branch_target`  in  PC_WIDTH  new PC when `branch_taken`.
- `prog_addr`  out  PC_WIDTH  ROM address; equals `pc` combinationally.
- `prog_en`  out  1  ROM read enable; ROM output register updates only when high.
- `prog_data`  in  16  ROM data, registered in ROM, valid one cycle after address with `prog_en`.
- `opcode`  out  3  decoded `prog_data[15:13]`.
- `rd_addr`  out  3  decoded `prog_data[12:10]`.
- `rs_addr`  out  3  decoded `prog_data[9:7]`.
- `immediate`  out  5  signed Q2.3, `prog_data[4:0]` passed unmodified; bits [6:5] are ignored.
- `dec_valid`  out  1  decoded fields hold a real instruction this cycle.
- `halted`  out  1  sticky halt flag.

## Operation
- Internal state: `pc`, `fetch_valid` (ROM output corresponds to an unsquashed fetch), decode registers, `halted`.
- Reset (async, `n_reset` low): `pc`=0, `fetch_valid`=0, `opcode`/`rd_addr`/`rs_addr`/`immediate`=0, `dec_valid`=0, `halted`=0. Reset asserted mid-operation discards all in-flight instructions immediately.
- `prog_en` = !`stall` && !`halted` || `branch_taken`.
- Priority per edge: `halted` > `branch_taken` > `stall` > normal.
- Normal: `pc` <= `pc`+1, wrapping from 2^PC_WIDTH-1 to 0 with no flag. `fetch_valid` <= 1. If `fetch_valid`, the decode registers capture the `prog_data` fields and `dec_valid` <= 1. Otherwise `dec_valid` <= 0.
- HALT: if `fetch_valid` and `prog_data[15:13]`==HALT_OP on a non-stall, non-branch edge, then `halted` <= 1 and `dec_valid` <= 0. The HALT instruction is never issued, and `pc` does not increment. `halted` clears only on reset.
- Halted: `pc`, `fetch_valid` and the decode fields hold. `dec_valid`=0. `branch_taken` and `stall` are ignored.
- Stall: `pc`, `fetch_valid`, the decode fields and `dec_valid` all hold. `prog_en`=0 so the ROM output holds, and no instruction is lost or duplicated.
- Branch: `pc` <= `branch_target`, `fetch_valid` <= 0 (squashes the word in the ROM register), `dec_valid` <= 0. Branch overrides a simultaneous `stall`. The decode fields hold their old values while invalid.

## Timing
- Fetch-to-issue latency is 2 cycles: `pc`=N in cycle t, `prog_data`=mem[N] in t+1, and fields valid with `dec_valid`=1 in t+2.
- After reset release, the first `dec_valid`=1 occurs in the 2nd cycle after the first rising edge with `n_reset` high.
- Branch penalty is 2 bubbles. A branch sampled at edge e gives `dec_valid`=0 for the cycles after e and e+1. The target instruction is issued after edge e+2.
- A stall of k cycles delays every subsequent issue by exactly k cycles. Issue order is unchanged.
- Steady state throughput is 1 instruction per cycle.

## Test plan
- Reset, then free-run a ROM with mem[i]={3'b001,3'd1,3'd2,2'b00,5'd6} for i=0..3 -> `dec_valid` rises 2 cycles after release. `immediate`=5'b00110 and `rs_addr`=2 each cycle, and `prog_addr` counts 0,1,2,3.
- Run with PC_WIDTH=8 from pc=254 -> `prog_addr` goes 254,255,0,1 and the instructions from 0x00 issue after the one from 0xFF, with no gap.
- Assert `stall` for 3 cycles mid-stream -> fields and `dec_valid` are frozen. The instruction sequence after release has no duplicate and no skipped word, and `prog_en`=0 during the stall.
- Assert `branch_taken` with `branch_target`=0x40, together with `stall` in the same cycle -> the branch wins. 2 cycles with `dec_valid`=0 follow, then mem[0x40] issues.
- Place HALT_OP at address 5 -> instructions 0..4 issue, `halted`=1 and `dec_valid`=0 thereafter, and `prog_addr` is frozen. A later `branch_taken` has no effect.
- Pulse `n_reset` low asynchronously (between edges) during a stall -> all outputs go to reset values immediately, and fetch restarts from address 0.

Source files
------------

// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - picoMIPS fetch/decode front-end stage
//
// Owns the program counter, drives the synchronous program ROM and registers
// the decoded instruction fields for the register file and execute stage.
//
// Ports:
//   clk            rising-edge clock
//   n_reset        asynchronous active-low reset
//   stall          execute back-pressure, freezes the stage
//   branch_taken   one-cycle redirect request from execute
//   branch_target  redirect PC
//   prog_addr      ROM address (= pc)
//   prog_en        ROM read enable; ROM output register only loads when high
//   prog_data      registered ROM word, one cycle after prog_addr/prog_en
//   opcode         prog_data[15:13]
//   rd_addr        prog_data[12:10]
//   rs_addr        prog_data[9:7]
//   immediate      signed Q2.3, prog_data[4:0]
//   dec_valid      decode fields hold an instruction to issue this cycle
//   halted         sticky halt flag, cleared only by reset

module fetch_decode #(
   parameter int         PC_WIDTH = 8,
   parameter logic [2:0] HALT_OP  = 3'b111
) (
   input  logic                clk,
   input  logic                n_reset,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_target,
   output logic [PC_WIDTH-1:0] prog_addr,
   output logic                prog_en,
   input  logic [15:0]         prog_data,
   output logic [2:0]          opcode,
   output logic [2:0]          rd_addr,
   output logic [2:0]          rs_addr,
   output logic [4:0]          immediate,
   output logic                dec_valid,
   output logic                halted
);

   logic [PC_WIDTH-1:0] pc;
   // ROM output register holds a word fetched from a non-squashed address
   logic                fetch_valid;
   // prog_data[6:5] carry no meaning for this stage
   logic                unused_bits;

   assign unused_bits = ^prog_data[6:5];
   assign prog_addr   = pc;
   // A branch must reload the ROM even while stalled so the target fetch starts
   assign prog_en     = (!stall && !halted) || branch_taken;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         pc          <= '0;
         fetch_valid <= 1'b0;
         opcode      <= 3'd0;
         rd_addr     <= 3'd0;
         rs_addr     <= 3'd0;
         immediate   <= 5'd0;
         dec_valid   <= 1'b0;
         halted      <= 1'b0;
      end else if (halted) begin
         dec_valid <= 1'b0;
      end else if (branch_taken) begin
         // Squash the word currently in the ROM register; fields keep stale values
         pc          <= branch_target;
         fetch_valid <= 1'b0;
         dec_valid   <= 1'b0;
      end else if (stall) begin
         // Everything holds; ROM output is frozen by prog_en so nothing is lost
      end else if (fetch_valid && prog_data[15:13] == HALT_OP) begin
         // HALT is never issued and pc stops where it is
         halted    <= 1'b1;
         dec_valid <= 1'b0;
      end else begin
         pc          <= pc + PC_WIDTH'(1);
         fetch_valid <= 1'b1;
         if (fetch_valid) begin
            opcode    <= prog_data[15:13];
            rd_addr   <= prog_data[12:10];
            rs_addr   <= prog_data[9:7];
            immediate <= prog_data[4:0];
            dec_valid <= 1'b1;
         end else begin
            dec_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_decode.sv
// tb/tb_fetch_decode.sv - directed self-checking bench for fetch_decode

module tb_fetch_decode;

   logic        clk;
   logic        n_reset;
   logic        stall;
   logic        branch_taken;
   logic [7:0]  branch_target;
   logic [7:0]  prog_addr;
   logic        prog_en;
   logic [15:0] prog_data;
   logic [2:0]  opcode;
   logic [2:0]  rd_addr;
   logic [2:0]  rs_addr;
   logic [4:0]  immediate;
   logic        dec_valid;
   logic        halted;

   logic [15:0] mem [256];
   int          n_assert;
   int          n_fail;

   fetch_decode #(.PC_WIDTH(8), .HALT_OP(3'b111)) dut (
      .clk           (clk),
      .n_reset       (n_reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .prog_addr     (prog_addr),
      .prog_en       (prog_en),
      .prog_data     (prog_data),
      .opcode        (opcode),
      .rd_addr       (rd_addr),
      .rs_addr       (rs_addr),
      .immediate     (immediate),
      .dec_valid     (dec_valid),
      .halted        (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM model with output register gated by prog_en
   always @(posedge clk) begin
      if (prog_en) prog_data <= mem[prog_addr];
   end

   // Default word: every field encodes part of the address; bits [6:5] set to prove they are ignored
   function automatic logic [15:0] word(input logic [7:0] a);
      return {2'b00, a[0], a[7:5], a[4:2], 2'b11, a[1:0], 3'b101};
   endfunction

   // Expected {opcode, rd_addr, rs_addr, immediate} for the default word at address a
   function automatic logic [15:0] fld(input logic [7:0] a);
      return {2'b00, 2'b00, a[0], a[7:5], a[4:2], a[1:0], 3'b101};
   endfunction

   function automatic logic [15:0] obs_fld();
      return {2'b00, opcode, rd_addr, rs_addr, immediate};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_issue(input string tag, input logic [7:0] addr_exp, input logic [7:0] src);
      chk({tag, ".dv"}, 16'(dec_valid), 16'd1);
      chk({tag, ".fld"}, obs_fld(), fld(src));
      chk({tag, ".addr"}, 16'(prog_addr), 16'(addr_exp));
   endtask

   task automatic chk_bubble(input string tag, input logic [7:0] addr_exp);
      chk({tag, ".dv"}, 16'(dec_valid), 16'd0);
      chk({tag, ".addr"}, 16'(prog_addr), 16'(addr_exp));
   endtask

   initial begin
      n_assert      = 0;
      n_fail        = 0;
      n_reset       = 1'b0;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 8'd0;
      for (int i = 0; i < 256; i++) mem[i] = word(8'(i));
      for (int i = 0; i < 4; i++) mem[i] = {3'b001, 3'd1, 3'd2, 2'b00, 5'd6};

      // Reset state
      #12;
      chk("rst.addr", 16'(prog_addr), 16'd0);
      chk("rst.dv", 16'(dec_valid), 16'd0);
      chk("rst.halted", 16'(halted), 16'd0);
      chk("rst.fld", obs_fld(), 16'd0);

      // Free run from reset: issue two cycles after release
      @(negedge clk);
      n_reset = 1'b1;
      #1 chk("run.prog_en", 16'(prog_en), 16'd1);
      step();
      chk_bubble("run.c1", 8'd1);
      step();
      chk("run.c2.dv", 16'(dec_valid), 16'd1);
      chk("run.c2.imm", 16'(immediate), 16'h06);
      chk("run.c2.rs", 16'(rs_addr), 16'd2);
      chk("run.c2.addr", 16'(prog_addr), 16'd2);
      step();
      chk("run.c3.imm", 16'(immediate), 16'h06);
      chk("run.c3.rs", 16'(rs_addr), 16'd2);
      chk("run.c3.addr", 16'(prog_addr), 16'd3);
      step();
      chk("run.c4.dv", 16'(dec_valid), 16'd1);
      chk("run.c4.rs", 16'(rs_addr), 16'd2);
      for (int i = 0; i < 4; i++) mem[i] = word(8'(i));

      // PC wrap 255 -> 0 with no gap
      branch_taken  = 1'b1;
      branch_target = 8'hFE;
      step();
      chk_bubble("wrap.b0", 8'hFE);
      branch_taken = 1'b0;
      step();
      chk_bubble("wrap.b1", 8'hFF);
      step();
      chk_issue("wrap.i0", 8'h00, 8'hFE);
      step();
      chk_issue("wrap.i1", 8'h01, 8'hFF);
      step();
      chk_issue("wrap.i2", 8'h02, 8'h00);
      step();
      chk_issue("wrap.i3", 8'h03, 8'h01);

      // Three-cycle stall: everything frozen, no loss or duplication
      stall = 1'b1;
      #1 chk("stall.prog_en0", 16'(prog_en), 16'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_issue("stall.hold", 8'h03, 8'h01);
         chk("stall.prog_en", 16'(prog_en), 16'd0);
      end
      stall = 1'b0;
      step();
      chk_issue("stall.r0", 8'h04, 8'h02);
      step();
      chk_issue("stall.r1", 8'h05, 8'h03);

      // Branch together with stall: branch wins, two bubbles, then target issues
      branch_taken  = 1'b1;
      stall         = 1'b1;
      branch_target = 8'h40;
      #1 chk("br.prog_en", 16'(prog_en), 16'd1);
      step();
      chk_bubble("br.b0", 8'h40);
      branch_taken = 1'b0;
      stall        = 1'b0;
      step();
      chk_bubble("br.b1", 8'h41);
      step();
      chk_issue("br.i0", 8'h42, 8'h40);
      step();
      chk_issue("br.i1", 8'h43, 8'h41);

      // HALT at address 5
      mem[5]        = {3'b111, 13'h0};
      branch_taken  = 1'b1;
      branch_target = 8'h00;
      step();
      chk_bubble("halt.b0", 8'h00);
      branch_taken = 1'b0;
      step();
      chk_bubble("halt.b1", 8'h01);
      for (int i = 0; i < 5; i++) begin
         step();
         chk_issue("halt.run", 8'(i + 2), 8'(i));
      end
      step();
      chk("halt.flag", 16'(halted), 16'd1);
      chk("halt.fld", obs_fld(), fld(8'h04));
      chk_bubble("halt.h0", 8'h06);
      chk("halt.prog_en", 16'(prog_en), 16'd0);
      branch_taken  = 1'b1;
      branch_target = 8'h10;
      step();
      chk_bubble("halt.br", 8'h06);
      chk("halt.flag2", 16'(halted), 16'd1);
      branch_taken = 1'b0;
      step();
      chk_bubble("halt.h2", 8'h06);

      // Asynchronous reset between edges during a stall
      stall = 1'b1;
      #2 n_reset = 1'b0;
      #1;
      chk("arst.addr", 16'(prog_addr), 16'd0);
      chk("arst.dv", 16'(dec_valid), 16'd0);
      chk("arst.halted", 16'(halted), 16'd0);
      chk("arst.fld", obs_fld(), 16'd0);
      @(negedge clk);
      n_reset = 1'b1;
      stall   = 1'b0;
      step();
      chk_bubble("arst.c1", 8'h01);
      step();
      chk_issue("arst.i0", 8'h02, 8'h00);
      step();
      chk_issue("arst.i1", 8'h03, 8'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
